// File: rtl/z80_io_decoder_pkg.sv
// Z80 I/O decoder shared definitions.
// State encodings, address-map prefixes, helpers.
package z80_io_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] CFG_PREFIX_DEF = 3'b110;

  localparam logic [2:0] RSV_PREFIX_A = 3'b100;
  localparam logic [2:0] RSV_PREFIX_B = 3'b101;
  localparam logic [2:0] RSV_PREFIX_C = 3'b111;

  localparam int N_DEV = 4;

  function automatic logic [N_DEV-1:0] dev_onehot(
    input logic [1:0] d
  );
    dev_onehot    = '0;
    dev_onehot[d] = 1'b1;
  endfunction

  function automatic logic is_rsv(
    input logic [2:0] p
  );
    return (p == RSV_PREFIX_A) ||
           (p == RSV_PREFIX_B) ||
           (p == RSV_PREFIX_C);
  endfunction

endpackage

// File: rtl/z80_io_decoder.sv
// Z80 I/O front end: port decode, cycle FSM,
// one-shot peripheral strobes.
module z80_io_decoder
  import z80_io_decoder_pkg::*;
#(
  parameter logic [2:0] CFG_PREFIX = CFG_PREFIX_DEF,
  parameter int         REG_W      = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_iorq_n,
  input  logic             i_m1_n,
  input  logic             i_rd_n,
  input  logic             i_wr_n,
  input  logic [7:0]       i_addr,
  input  logic [7:0]       i_data,
  input  logic             i_wait,
  output logic             o_wsg_iorq_n,
  output logic             o_wsg_cs_n,
  output logic [1:0]       o_wsg_device,
  output logic [N_DEV-1:0] o_dev_sel,
  output logic [REG_W-1:0] o_reg,
  output logic [7:0]       o_wdata,
  output logic             o_rd_stb,
  output logic             o_wr_stb,
  output logic             o_unmapped,
  output logic             o_busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_DEV-1:0] r_dev;
  logic [N_DEV-1:0] w_dev_nxt;
  logic [REG_W-1:0] r_reg;
  logic [REG_W-1:0] w_reg_nxt;
  logic [7:0]       r_wdata;
  logic [7:0]       w_wdata_nxt;
  logic             r_wr_dir;
  logic             w_wr_dir_nxt;
  logic             r_rd_stb;
  logic             w_rd_stb_nxt;
  logic             r_wr_stb;
  logic             w_wr_stb_nxt;
  logic             r_unm;
  logic             w_unm_nxt;
  logic             w_start;
  logic             w_cfg;
  logic             w_rsv;

  // INTA and M1 cycles never reach the wait-state generator
  assign o_wsg_iorq_n = i_iorq_n | i_addr[7] | ~i_m1_n;
  assign o_wsg_cs_n   = (i_addr[7:5] != CFG_PREFIX)
                      | i_iorq_n | ~i_m1_n;
  assign o_wsg_device = i_addr[6:5];

  // exactly one of RD/WR low; both low is not a cycle
  assign w_start = ~i_iorq_n & i_m1_n & (i_rd_n ^ i_wr_n);
  assign w_cfg   = (i_addr[7:5] == CFG_PREFIX);
  assign w_rsv   = is_rsv(i_addr[7:5]) & ~w_cfg;

  assign o_dev_sel  = r_dev;
  assign o_reg      = r_reg;
  assign o_wdata    = r_wdata;
  assign o_rd_stb   = r_rd_stb;
  assign o_wr_stb   = r_wr_stb;
  assign o_unmapped = r_unm;
  assign o_busy     = (r_state != ST_IDLE);

  // state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and next registered outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_dev_nxt    = r_dev;
    w_reg_nxt    = r_reg;
    w_wdata_nxt  = r_wdata;
    w_wr_dir_nxt = r_wr_dir;
    w_rd_stb_nxt = 1'b0;
    w_wr_stb_nxt = 1'b0;
    w_unm_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_reg_nxt    = i_addr[REG_W-1:0];
          w_wr_dir_nxt = ~i_wr_n;
          if (!i_wr_n) begin
            w_wdata_nxt = i_data;
          end
          if (!i_addr[7]) begin
            w_dev_nxt   = dev_onehot(i_addr[6:5]);
            w_state_nxt = ST_ACCESS;
          end else begin
            w_unm_nxt   = w_rsv;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_ACCESS: begin
        if (i_iorq_n) begin
          w_dev_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (!i_wait) begin
          w_rd_stb_nxt = ~r_wr_dir;
          w_wr_stb_nxt = r_wr_dir;
          w_state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_iorq_n) begin
          w_dev_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_dev_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // registered outputs and latched cycle info
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dev    <= '0;
      r_reg    <= '0;
      r_wdata  <= '0;
      r_wr_dir <= 1'b0;
      r_rd_stb <= 1'b0;
      r_wr_stb <= 1'b0;
      r_unm    <= 1'b0;
    end else begin
      r_dev    <= w_dev_nxt;
      r_reg    <= w_reg_nxt;
      r_wdata  <= w_wdata_nxt;
      r_wr_dir <= w_wr_dir_nxt;
      r_rd_stb <= w_rd_stb_nxt;
      r_wr_stb <= w_wr_stb_nxt;
      r_unm    <= w_unm_nxt;
    end
  end

endmodule

// File: tb/tb_z80_io_decoder.sv
// Bench for z80_io_decoder: transaction-level
// expectations, per-cycle compare, directed pins.
module tb_z80_io_decoder;

  logic       clk;
  logic       rst_n;
  logic       iorq_n;
  logic       m1_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] addr;
  logic [7:0] data;
  logic       wait_i;
  logic       wsg_iorq_n;
  logic       wsg_cs_n;
  logic [1:0] wsg_device;
  logic [3:0] dev_sel;
  logic [4:0] reg_o;
  logic [7:0] wdata;
  logic       rd_stb;
  logic       wr_stb;
  logic       unmapped;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bit         chk_en = 0;
  bit         exp_busy;
  logic [3:0] exp_dev;
  bit         exp_rd;
  bit         exp_wr;
  bit         exp_unm;
  logic [4:0] m_reg;
  logic [7:0] m_wdata;

  int         obs_stb_n;
  int         obs_stb_k;
  int         obs_rd_n;
  int         obs_unm_n;
  int         obs_busy_n;
  logic [3:0] obs_dev;
  logic [3:0] obs_dev_or;
  logic       obs_cs0;
  logic       obs_io0;

  z80_io_decoder dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_iorq_n     (iorq_n),
    .i_m1_n       (m1_n),
    .i_rd_n       (rd_n),
    .i_wr_n       (wr_n),
    .i_addr       (addr),
    .i_data       (data),
    .i_wait       (wait_i),
    .o_wsg_iorq_n (wsg_iorq_n),
    .o_wsg_cs_n   (wsg_cs_n),
    .o_wsg_device (wsg_device),
    .o_dev_sel    (dev_sel),
    .o_reg        (reg_o),
    .o_wdata      (wdata),
    .o_rd_stb     (rd_stb),
    .o_wr_stb     (wr_stb),
    .o_unmapped   (unmapped),
    .o_busy       (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // per-cycle compare against the transaction model
  always @(negedge clk) begin
    if (chk_en) begin
      bit io_sel;
      bit cs_sel;
      io_sel = !iorq_n && m1_n && addr < 8'h80;
      cs_sel = !iorq_n && m1_n && addr >= 8'hC0 && addr < 8'hE0;
      chk("wsg_iorq_n", wsg_iorq_n, !io_sel);
      chk("wsg_cs_n", wsg_cs_n, !cs_sel);
      chk("wsg_device", wsg_device, (addr / 32) % 4);
      chk("busy", busy, exp_busy);
      chk("dev_sel", dev_sel, exp_dev);
      chk("rd_stb", rd_stb, exp_rd);
      chk("wr_stb", wr_stb, exp_wr);
      chk("unmapped", unmapped, exp_unm);
      chk("reg", reg_o, m_reg);
      chk("wdata", wdata, m_wdata);
    end
  end

  task automatic set_idle_exp();
    exp_busy = 0;
    exp_dev  = 4'd0;
    exp_rd   = 0;
    exp_wr   = 0;
    exp_unm  = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_idle_exp();
      @(negedge clk);
    end
  endtask

  // One bus cycle: IORQ low sampled at edges 0..l-1,
  // WAIT high sampled at edges 1..w.
  task automatic txn(
    input logic [7:0] a,
    input logic [7:0] d,
    input bit         wr,
    input bit         both,
    input bit         m1n,
    input int         w,
    input int         l
  );
    bit start, per, cfg, rsv;
    int sk;
    start = m1n && !both;
    per   = start && a < 8'h80;
    cfg   = start && a >= 8'hC0 && a < 8'hE0;
    rsv   = start && a >= 8'h80 && !cfg;
    sk    = (per && (1 + w) < l) ? 1 + w : -1;
    obs_stb_n  = 0;
    obs_stb_k  = -1;
    obs_rd_n   = 0;
    obs_unm_n  = 0;
    obs_busy_n = 0;
    obs_dev    = 4'd0;
    obs_dev_or = 4'd0;
    addr   = a;
    data   = d;
    m1_n   = m1n;
    rd_n   = both ? 1'b0 : wr;
    wr_n   = both ? 1'b0 : !wr;
    iorq_n = 0;
    wait_i = 1'($urandom_range(0, 1));
    #1;
    obs_cs0 = wsg_cs_n;
    obs_io0 = wsg_iorq_n;
    for (int k = 0; k <= l; k++) begin
      @(posedge clk); #1;
      if (k == 0 && start) begin
        m_reg = a[4:0];
        if (wr) m_wdata = d;
      end
      exp_busy = start && k < l;
      exp_dev  = (per && k < l) ?
                 (4'b0001 << (a / 32)) : 4'd0;
      exp_rd   = (k == sk) && !wr;
      exp_wr   = (k == sk) && wr;
      exp_unm  = rsv && k == 0;
      if (k + 1 >= l) begin
        iorq_n = 1;
        rd_n   = 1;
        wr_n   = 1;
        m1_n   = 1;
      end
      if (k + 1 <= w) wait_i = 1;
      else if (k + 1 == sk) wait_i = 0;
      else wait_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rd_stb || wr_stb) begin
        obs_stb_n++;
        obs_stb_k = k;
        obs_dev   = dev_sel;
      end
      if (rd_stb) obs_rd_n++;
      if (unmapped) obs_unm_n++;
      if (busy) obs_busy_n++;
      obs_dev_or = obs_dev_or | dev_sel;
    end
  endtask

  initial begin
    rst_n  = 0;
    iorq_n = 0;
    m1_n   = 1;
    rd_n   = 0;
    wr_n   = 1;
    addr   = 8'h20;
    data   = 8'h00;
    wait_i = 0;
    m_reg   = 5'd0;
    m_wdata = 8'd0;
    set_idle_exp();
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_dev", dev_sel, 0);
    chk("rst_reg", reg_o, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pulses", {rd_stb, wr_stb, unmapped}, 0);
    chk("rst_wsg_iorq", wsg_iorq_n, 0);
    chk("rst_wsg_cs", wsg_cs_n, 1);
    chk("rst_wsg_dev", wsg_device, 2'd1);
    iorq_n = 1;
    rd_n   = 1;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk_en = 1;
    idle(2);

    txn(8'h23, 8'h5A, 1, 0, 1, 2, 6);
    chk("p23_stb_n", obs_stb_n, 1);
    chk("p23_stb_k", obs_stb_k, 3);
    chk("p23_rd_n", obs_rd_n, 0);
    chk("p23_dev", obs_dev, 4'b0010);
    chk("p23_reg", reg_o, 5'd3);
    chk("p23_wdata", wdata, 8'h5A);
    idle(1);

    txn(8'h61, 8'h00, 0, 0, 1, 0, 3);
    chk("p61_stb_k", obs_stb_k, 1);
    chk("p61_rd_n", obs_rd_n, 1);
    chk("p61_dev", obs_dev, 4'b1000);
    chk("p61_busy_n", obs_busy_n, 3);
    idle(1);

    txn(8'hC0, 8'h11, 1, 0, 1, 0, 3);
    chk("pC0_cs0", obs_cs0, 0);
    chk("pC0_io0", obs_io0, 1);
    chk("pC0_stb_n", obs_stb_n, 0);
    chk("pC0_unm_n", obs_unm_n, 0);
    idle(1);

    txn(8'hE4, 8'h00, 0, 0, 1, 0, 3);
    chk("pE4_unm_n", obs_unm_n, 1);
    chk("pE4_stb_n", obs_stb_n, 0);
    chk("pE4_dev", obs_dev_or, 4'd0);
    idle(1);

    txn(8'h00, 8'h00, 0, 0, 0, 0, 3);
    chk("inta_busy_n", obs_busy_n, 0);
    chk("inta_io0", obs_io0, 1);
    chk("inta_cs0", obs_cs0, 1);
    chk("inta_pulses", obs_stb_n + obs_unm_n, 0);
    idle(1);

    txn(8'h00, 8'h77, 1, 0, 1, 5, 3);
    chk("abort_stb_n", obs_stb_n, 0);
    chk("abort_busy_n", obs_busy_n, 3);
    idle(2);

    chk_en = 0;
    addr   = 8'h00;
    data   = 8'hA5;
    m1_n   = 1;
    rd_n   = 1;
    wr_n   = 0;
    wait_i = 1;
    iorq_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    chk("mid_dev", dev_sel, 4'b0001);
    chk("mid_wdata", wdata, 8'hA5);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_dev", dev_sel, 0);
    chk("arst_reg", reg_o, 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_pulses", {rd_stb, wr_stb, unmapped}, 0);
    iorq_n = 1;
    wr_n   = 1;
    @(posedge clk); #1;
    rst_n   = 1;
    m_reg   = 5'd0;
    m_wdata = 8'd0;
    set_idle_exp();
    @(negedge clk);
    chk_en = 1;
    idle(2);

    for (int t = 0; t < 300; t++) begin
      int  sel;
      bit  m1n;
      bit  both;
      sel  = $urandom_range(0, 9);
      m1n  = (sel != 0);
      both = (sel == 1);
      txn(8'($urandom), 8'($urandom),
          1'($urandom_range(0, 1)), both, m1n,
          $urandom_range(0, 3), $urandom_range(1, 7));
      idle($urandom_range(1, 3));
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_io_decoder.md
Name: z80_io_decoder

Overview:
- Upstream front end of the Z80 I/O path. It decodes the 8-bit I/O port address and drives the wait-state generator's select inputs combinationally.
- It tracks each I/O cycle with a small FSM and issues single-clock read/write strobes to the selected peripheral once the wait-state generator releases WAIT.
- Z80 bus signals are synchronous to i_clk; the Z80 clock is i_clk.

Parameters:
- CFG_PREFIX, 3'b110: addr[7:5] value that selects the wait-state generator configuration registers.
- REG_W, 5: width of the latched peripheral register index, addr[4:0].

Ports:
- i_clk  in  1  system/Z80 clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_iorq_n  in  1  Z80 IORQ.
- i_m1_n  in  1  Z80 M1; low together with IORQ means interrupt acknowledge.
- i_rd_n  in  1  Z80 RD.
- i_wr_n  in  1  Z80 WR.
- i_addr  in  8  Z80 A[7:0].
- i_data  in  8  Z80 data bus, write data.
- i_wait  in  1  o_wait from the wait-state generator; 1 = stall.
- o_wsg_iorq_n  out  1  comb: i_iorq_n | i_addr[7] | ~i_m1_n.
- o_wsg_cs_n  out  1  comb: (i_addr[7:5] != CFG_PREFIX) | i_iorq_n | ~i_m1_n.
- o_wsg_device  out  2  comb: i_addr[6:5].
- o_dev_sel  out  4  registered one-hot peripheral select; valid while o_busy.
- o_reg  out  REG_W  latched addr[4:0].
- o_wdata  out  8  latched write data.
- o_rd_stb  out  1  one-cycle read strobe.
- o_wr_stb  out  1  one-cycle write strobe.
- o_unmapped  out  1  one-cycle pulse on an access to reserved space.
- o_busy  out  1  FSM not IDLE.

Behaviour:
- Address map:
  - addr[7]=0: peripheral d = addr[6:5], register = addr[4:0].
  - addr[7:5]=CFG_PREFIX: wait-state generator configuration. This block only asserts o_wsg_cs_n; it never strobes peripherals.
  - addr[7:5]=100/101/111: reserved.
- Reset (async, i_reset_n=0): state=IDLE. o_dev_sel=0, o_reg=0, o_wdata=0. o_rd_stb, o_wr_stb, o_unmapped, o_busy all 0. Combinational outputs follow their inputs even while in reset.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Start condition, sampled at a posedge: i_iorq_n=0, i_m1_n=1, and (i_rd_n=0 xor i_wr_n=0).
  - On start: latch addr[4:0] to o_reg and the direction flag. If a write, latch i_data to o_wdata. Then:
    - peripheral space: o_dev_sel=1<<addr[6:5], go ACCESS.
    - config space: go DONE, no pulse.
    - reserved space: o_unmapped=1 for one cycle, go DONE.
  - IORQ with M1 low (INTA) is ignored; stay IDLE.
  - rd_n and wr_n both low is illegal; treat as no start.
- ACCESS:
  - At each posedge, if i_iorq_n=1, the cycle is aborted: go IDLE, o_dev_sel=0, no strobe.
  - Else if i_wait=0: o_rd_stb or o_wr_stb = 1 for exactly the next cycle (per the latched direction), go DONE.
  - Else (i_wait=1): remain in ACCESS.
- DONE: hold o_dev_sel. When i_iorq_n is sampled 1, go IDLE and clear o_dev_sel. Exactly one strobe per IORQ assertion, even if i_wait toggles afterwards.
- Latency:
  - Start sampled at edge E0 puts the FSM in ACCESS after E0.
  - With i_wait=0 at E1, the strobe is high from E1 to E2.
  - Each clock with i_wait=1 delays the strobe by one clock.
- o_busy = (state != IDLE).
- Strobes and o_unmapped are registered; they are never asserted simultaneously.

Decomposition:
- Shared package/include z80_io_defs.vh holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - CFG_PREFIX default;
  - reserved-prefix constants;
  - the device count (4).
- No sub-module. The combinational decode is small enough to remain inline.

Test Plan:
- Write port 0x23, data 0x5A, i_wait=1 for 2 clocks after entering ACCESS -> o_dev_sel=4'b0010, o_reg=5'd3, o_wdata=0x5A; o_wr_stb high exactly one cycle, on the 3rd ACCESS edge; no o_rd_stb.
- Read port 0x61, i_wait=0 -> o_dev_sel=4'b1000; o_rd_stb one cycle starting 1 clock after start sample; o_busy clears the clock after IORQ rises.
- Write port 0xC0 -> o_wsg_cs_n=0 during IORQ; o_wsg_iorq_n=1; no strobe; o_unmapped=0.
- Read port 0xE4 -> o_unmapped one-cycle pulse; no strobe; o_dev_sel=0.
- INTA (iorq_n=0, m1_n=0, addr=0x00) -> o_busy stays 0; o_wsg_iorq_n=1; o_wsg_cs_n=1; no pulses.
- Two abort/reset cases:
  - Port 0x00 write with i_wait=1, IORQ released after 2 clocks -> back to IDLE, no strobe.
  - Same access with i_reset_n pulsed low mid-ACCESS -> all registered outputs 0 immediately (asynchronous).
